// File: rtl/bus_dir_sched.sv
// Databus direction sequencer: arbitrates host byte loads into P_S against S_P reads, with turnaround gaps.
// Optional SCHED_DBIT_TRACK_EN: WR_SER ends on a Dbit_ena falling edge, with SER_CYCLES acting as a timeout that sets err.
module bus_dir_sched #(
  parameter int SER_CYCLES  = 10,
  parameter int TURN_CYCLES = 1,
  parameter int READ_HOLD   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_req,
  output logic wr_ack,
  input  logic rd_req,
  output logic rd_ack,
  output logic rd_valid,
  output logic ext_oe,
  output logic use_p_in_bus,
  output logic nGet_AD_data,
  input  logic Dbit_ena,
  output logic busy
`ifdef SCHED_DBIT_TRACK_EN
  ,
  output logic err
`endif
);

  localparam int SW = $clog2(SER_CYCLES) + 1;
  localparam int TW = $clog2(TURN_CYCLES) + 1;
  localparam int HW = $clog2(READ_HOLD) + 1;

  localparam logic [SW-1:0] SER_LOAD  = SW'(SER_CYCLES - 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(READ_HOLD - 1);
  localparam logic [SW-1:0] SER_ONE   = SW'(1);
  localparam logic [TW-1:0] TURN_ONE  = TW'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic          LAST_ON_ENTRY = (READ_HOLD == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_TURN,
    S_WR_LOAD,
    S_WR_SER,
    S_RD_TURN,
    S_RD_DRIVE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_HOST,
    OWN_SP
  } owner_t;

  typedef enum logic {
    GNT_WRITE,
    GNT_READ
  } grant_t;

  state_t         state;
  owner_t         owner;
  grant_t         last_grant;
  logic [TW-1:0]  turn_cnt;
  logic [SW-1:0]  ser_cnt;
  logic [HW-1:0]  hold_cnt;
  logic           grant_wr;
  logic           grant_rd;

  // On a tie the side that did not win last time takes the bus.
  assign grant_wr = wr_req && (!rd_req || (last_grant == GNT_READ));
  assign grant_rd = rd_req && !grant_wr;

`ifdef SCHED_DBIT_TRACK_EN
  logic dbit_q;
  logic dbit_fall;
  assign dbit_fall = dbit_q && !Dbit_ena;
`else
  logic unused_dbit;
  assign unused_dbit = Dbit_ena;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      owner        <= OWN_NONE;
      last_grant   <= GNT_READ;
      turn_cnt     <= '0;
      ser_cnt      <= '0;
      hold_cnt     <= '0;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      ext_oe       <= 1'b0;
      use_p_in_bus <= 1'b1;
      nGet_AD_data <= 1'b1;
      busy         <= 1'b0;
`ifdef SCHED_DBIT_TRACK_EN
      dbit_q       <= 1'b0;
      err          <= 1'b0;
`endif
    end else begin
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      ext_oe       <= 1'b0;
      use_p_in_bus <= 1'b1;
      nGet_AD_data <= 1'b1;
      busy         <= 1'b1;
`ifdef SCHED_DBIT_TRACK_EN
      dbit_q       <= Dbit_ena;
`endif
      case (state)
        S_IDLE: begin
          if (grant_wr) begin
            last_grant <= GNT_WRITE;
            if (owner == OWN_SP) begin
              state    <= S_WR_TURN;
              turn_cnt <= TURN_LOAD;
            end else begin
              state        <= S_WR_LOAD;
              ext_oe       <= 1'b1;
              nGet_AD_data <= 1'b0;
              wr_ack       <= 1'b1;
              owner        <= OWN_HOST;
            end
          end else if (grant_rd) begin
            last_grant <= GNT_READ;
            if (owner != OWN_SP) begin
              state    <= S_RD_TURN;
              turn_cnt <= TURN_LOAD;
            end else begin
              state        <= S_RD_DRIVE;
              hold_cnt     <= HOLD_LOAD;
              use_p_in_bus <= 1'b0;
              owner        <= OWN_SP;
              rd_ack       <= LAST_ON_ENTRY;
              rd_valid     <= LAST_ON_ENTRY;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        S_WR_TURN: begin
          if (!wr_req) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (turn_cnt == '0) begin
            state        <= S_WR_LOAD;
            ext_oe       <= 1'b1;
            nGet_AD_data <= 1'b0;
            wr_ack       <= 1'b1;
            owner        <= OWN_HOST;
          end else begin
            turn_cnt <= turn_cnt - TURN_ONE;
          end
        end

        S_WR_LOAD: begin
          state   <= S_WR_SER;
          ser_cnt <= SER_LOAD;
        end

        S_WR_SER: begin
`ifdef SCHED_DBIT_TRACK_EN
          if (dbit_fall) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (ser_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            ser_cnt <= ser_cnt - SER_ONE;
          end
`else
          if (ser_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            ser_cnt <= ser_cnt - SER_ONE;
          end
`endif
        end

        S_RD_TURN: begin
          if (!rd_req) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (turn_cnt == '0) begin
            state        <= S_RD_DRIVE;
            hold_cnt     <= HOLD_LOAD;
            use_p_in_bus <= 1'b0;
            owner        <= OWN_SP;
            rd_ack       <= LAST_ON_ENTRY;
            rd_valid     <= LAST_ON_ENTRY;
          end else begin
            turn_cnt <= turn_cnt - TURN_ONE;
          end
        end

        S_RD_DRIVE: begin
          // hold_cnt==1 here means the cycle being entered is the last drive cycle.
          if (hold_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt     <= hold_cnt - HOLD_ONE;
            use_p_in_bus <= 1'b0;
            if (hold_cnt == HOLD_ONE) begin
              rd_ack   <= 1'b1;
              rd_valid <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dir_sched.sv
// Bench for bus_dir_sched: transaction-level plan model, directed scenarios, then random host traffic.
module tb_bus_dir_sched;

  localparam int SER  = 10;
  localparam int TURN = 1;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic wr_req = 1'b0;
  logic rd_req = 1'b0;
  logic Dbit_ena = 1'b0;
  logic wr_ack, rd_ack, rd_valid, ext_oe, use_p_in_bus, nGet_AD_data, busy;

  bus_dir_sched #(
    .SER_CYCLES (SER),
    .TURN_CYCLES(TURN),
    .READ_HOLD  (HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_ack      (wr_ack),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .ext_oe      (ext_oe),
    .use_p_in_bus(use_p_in_bus),
    .nGet_AD_data(nGet_AD_data),
    .Dbit_ena    (Dbit_ena),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef enum {K_IDLE, K_WTURN, K_LOAD, K_SER, K_RTURN, K_DRIVE, K_LAST} kind_t;

  kind_t cur;
  kind_t plan[$];
  int    m_owner;    // 0 none, 1 host, 2 S_P
  bit    m_last_wr;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_drv;
  int    idle_run;
  int    wack_cyc[$];
  bit    ack_seq[$];

  function automatic logic [6:0] expect_out(kind_t k);
    // {wr_ack, rd_ack, rd_valid, ext_oe, use_p_in_bus, nGet_AD_data, busy}
    case (k)
      K_IDLE:                 return 7'b0000110;
      K_WTURN, K_RTURN, K_SER: return 7'b0000111;
      K_LOAD:                 return 7'b1001101;
      K_DRIVE:                return 7'b0000011;
      K_LAST:                 return 7'b0110011;
      default:                return 7'b0000110;
    endcase
  endfunction

  task automatic model_reset();
    cur = K_IDLE;
    plan.delete();
    m_owner = 0;
    m_last_wr = 1'b0;
    last_drv = 0;
    idle_run = 0;
  endtask

  task automatic model_edge();
    bit gw, gr;
    gw = wr_req && (!rd_req || !m_last_wr);
    gr = rd_req && !gw;
    if (cur == K_IDLE) begin
      if (gw) begin
        m_last_wr = 1'b1;
        if (m_owner == 2) repeat (TURN) plan.push_back(K_WTURN);
        plan.push_back(K_LOAD);
        repeat (SER) plan.push_back(K_SER);
      end else if (gr) begin
        m_last_wr = 1'b0;
        if (m_owner != 2) repeat (TURN) plan.push_back(K_RTURN);
        repeat (HOLD - 1) plan.push_back(K_DRIVE);
        plan.push_back(K_LAST);
      end
    end else if ((cur == K_WTURN && !wr_req) || (cur == K_RTURN && !rd_req)) begin
      plan.delete();
    end
    cur = (plan.size() > 0) ? plan.pop_front() : K_IDLE;
    if (cur == K_LOAD) m_owner = 1;
    if (cur == K_DRIVE || cur == K_LAST) m_owner = 2;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    logic [6:0] o;
    int d;
    o = {wr_ack, rd_ack, rd_valid, ext_oe, use_p_in_bus, nGet_AD_data, busy};
    chk("outputs", 32'(o), 32'(expect_out(cur)));
    chk("no_overlap", 32'(ext_oe && !use_p_in_bus), 0);
    d = ext_oe ? 1 : (!use_p_in_bus ? 2 : 0);
    if (d == 0) begin
      idle_run++;
    end else begin
      if (last_drv != 0 && d != last_drv) chk("turn_gap", 32'(idle_run >= TURN), 1);
      last_drv = d;
      idle_run = 0;
    end
    if (wr_ack) begin
      wack_cyc.push_back(cyc);
      ack_seq.push_back(1'b1);
    end
    if (rd_ack) ack_seq.push_back(1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({wr_ack, rd_ack, rd_valid, ext_oe, use_p_in_bus, nGet_AD_data, busy}), 32'h06);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int found;
    int c2;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({wr_ack, rd_ack, rd_valid, ext_oe, use_p_in_bus, nGet_AD_data, busy}), 32'h06);
    rst_n = 1'b1;

    // single write from reset: LOAD in cycle 1, SER cycles 2..11, IDLE at 12
    wr_req = 1'b1;
    step();
    chk("wr_first_nget", 32'(nGet_AD_data), 0);
    wr_req = 1'b0;
    repeat (12) step();

    // single read from reset: turn, two drive cycles, ack on the second
    do_reset();
    rd_req = 1'b1;
    repeat (3) step();
    chk("rd_ack_cycle3", 32'(rd_ack), 1);
    rd_req = 1'b0;
    repeat (2) step();

    // both requests held: grants alternate starting with write
    do_reset();
    ack_seq.delete();
    wr_req = 1'b1;
    rd_req = 1'b1;
    repeat (80) step();
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (15) step();
    chk("alt_count", 32'(ack_seq.size() >= 4), 1);
    if (ack_seq.size() > 0) chk("alt_first_write", 32'(ack_seq[0]), 1);
    for (int i = 1; i < ack_seq.size(); i++) chk("alternate", 32'(ack_seq[i] != ack_seq[i-1]), 1);

    // back-to-back writes, then a read needing turnaround
    do_reset();
    wack_cyc.delete();
    wr_req = 1'b1;
    for (int i = 0; i < 40 && wack_cyc.size() < 2; i++) step();
    wr_req = 1'b0;
    rd_req = 1'b1;
    chk("two_wr_acks", wack_cyc.size(), 2);
    c2 = (wack_cyc.size() >= 2) ? wack_cyc[1] : 0;
    if (wack_cyc.size() >= 2) chk("wr_spacing", wack_cyc[1] - wack_cyc[0], SER + 2);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (!use_p_in_bus) found = 1;
    end
    chk("rd_drive_seen", found, 1);
    chk("rd_after_wr_gap", cyc - c2, SER + TURN + 2);
    step();
    rd_req = 1'b0;
    repeat (3) step();

    // asynchronous reset in the middle of a read drive
    do_reset();
    rd_req = 1'b1;
    repeat (2) step();
    chk("driving_before_reset", 32'(use_p_in_bus), 0);
    rst_n = 1'b0;
    #1;
    chk("async_use_p", 32'(use_p_in_bus), 1);
    chk("async_busy", 32'(busy), 0);
    chk("async_rd_ack", 32'(rd_ack), 0);
    rd_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wr_req = 1'b1;
    step();
    chk("wr_no_turn_after_reset", 32'(nGet_AD_data), 0);
    wr_req = 1'b0;
    repeat (12) step();

    // random host traffic, including drops during turnaround
    for (int n = 0; n < 800; n++) begin
      step();
      if (wr_req && wr_ack) wr_req = 1'b0;
      else if (!wr_req) wr_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 11) == 0) wr_req = 1'b0;
      if (rd_req && rd_ack) rd_req = 1'b0;
      else if (!rd_req) rd_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 11) == 0) rd_req = 1'b0;
      Dbit_ena = 1'($urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_dir_sched.md
Name: bus_dir_sched

Overview:
Sequencer/arbiter for the shared 8-bit bidirectional databus between the parallel-to-serial loader and the serial-to-parallel result path. Arbitrates a host write request (load a byte into P_S) against a host read request (sample the S_P byte from the bus). Generates use_p_in_bus and nGet_AD_data, plus a host output-enable. Guarantees the host and S_P never drive the bus together, with a turnaround gap between drivers.

Parameters:
SER_CYCLES, 10, cycles reserved after a load for P_S to finish serialising (min 1)
TURN_CYCLES, 1, bus-idle cycles inserted on driver change (min 1)
READ_HOLD, 2, cycles S_P drives the bus per read (min 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_req  input  1  host wants to load a byte; level, held until wr_ack
wr_ack  output  1  one-cycle pulse; host byte is on the bus and latched this cycle
rd_req  input  1  host wants the S_P byte; level, held until rd_ack
rd_ack  output  1  one-cycle pulse on the last RD_DRIVE cycle
rd_valid  output  1  databus holds valid S_P data (same cycle as rd_ack)
ext_oe  output  1  host may drive databus
use_p_in_bus  output  1  1 = S_P tri-stated; 0 = S_P drives databus
nGet_AD_data  output  1  active-low load strobe to P_S
Dbit_ena  input  1  P_S serial-stream enable (monitored only with optional feature)
busy  output  1  1 in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. All state and outputs are registered.
- Reset values (applied immediately on rst_n low, including mid-operation): use_p_in_bus=1, ext_oe=0, nGet_AD_data=1, wr_ack=0, rd_ack=0, rd_valid=0, busy=0, state=IDLE, owner=NONE, last_grant=READ, all counters 0. The bus is released at once.
- owner register: NONE/HOST/SP, records the last driver of the bus.
- States:
  - IDLE: outputs at reset values.
  - WR_TURN: entered only if owner=SP. Bus idle for TURN_CYCLES cycles.
  - WR_LOAD: 1 cycle. ext_oe=1, nGet_AD_data=0, wr_ack=1. Sets owner=HOST.
  - WR_SER: SER_CYCLES cycles. ext_oe=0, busy=1. Then returns to IDLE.
  - RD_TURN: entered only if owner≠SP. Bus idle for TURN_CYCLES cycles.
  - RD_DRIVE: READ_HOLD cycles. use_p_in_bus=0, which sets owner=SP. On the last cycle rd_valid=1 and rd_ack=1. The next cycle is IDLE with use_p_in_bus=1.
- Latency: a request sampled in IDLE at edge N enters the first active state at N+1.
  - Write with no turnaround: nGet_AD_data is low during cycle N+1.
  - Read with turnaround: first drive cycle is N+1+TURN_CYCLES.
- Arbitration in IDLE:
  - Single requester wins.
  - If both are asserted, grant the one that is not last_grant (round-robin). last_grant updates on grant.
  - The first simultaneous request after reset goes to write.
- A request dropped during a TURN state aborts to IDLE with no ack. Drops during WR_LOAD/WR_SER/RD_DRIVE are ignored; the sequence completes.
- Invariant, every cycle: never (ext_oe=1 and use_p_in_bus=0). Any switch between host and S_P drive is separated by ≥TURN_CYCLES cycles with ext_oe=0 and use_p_in_bus=1.
- Back-to-back writes: owner stays HOST, so there is no turnaround. WR_LOAD repeats every SER_CYCLES+2 cycles (LOAD, SER, IDLE).
- Counters are sized clog2 of the parameter value plus 1 and reload on state entry.

Optional Feature:
SCHED_DBIT_TRACK_EN:
- Defined: WR_SER exits early on the first falling edge of Dbit_ena seen after WR_LOAD, leaving one cycle later. The SER_CYCLES counter becomes a timeout. A timeout without that falling edge sets a sticky output err (1 bit, reset 0, cleared only by rst_n) and returns to IDLE.
- Undefined: the err port is absent, Dbit_ena is unused, and WR_SER always lasts exactly SER_CYCLES.

Test Plan:
- Reset, then wr_req=1 at edge 0 (defaults) -> cycle 1: nGet_AD_data=0, ext_oe=1, wr_ack=1; cycles 2–11: busy=1, ext_oe=0; cycle 12: IDLE.
- After reset, rd_req=1 at edge 0 -> cycle 1: turn (use_p_in_bus=1, ext_oe=0); cycles 2–3: use_p_in_bus=0; cycle 3: rd_valid=rd_ack=1; cycle 4: use_p_in_bus=1.
- wr_req and rd_req both high continuously -> grants alternate W,R,W,R starting with W. Each switch shows ≥1 idle bus cycle. The invariant checker never fires.
- Two consecutive writes -> wr_ack pulses 12 cycles apart with no turnaround. Then a read -> 1 turnaround cycle before use_p_in_bus=0.
- rst_n low during RD_DRIVE -> use_p_in_bus=1 and busy=0 asynchronously, before the next clk edge. A following write takes no turnaround (owner=NONE).
- With SCHED_DBIT_TRACK_EN: Dbit_ena falls 4 cycles after WR_LOAD -> IDLE one cycle later, err=0. With Dbit_ena held high -> timeout after 10 cycles, err=1 sticky.
